// File: rtl/inert_burst_rdr.sv
// -----------------------------------------------------------------------------
// inert_burst_rdr
//
// Inertial-sensor read sequencer. After reset it waits 2^POR_BITS clocks and
// then configures the sensor with four fixed SPI writes. After that, each
// synchronized INT starts a burst that reads NUM_CH 16-bit channels from the
// sensor, low byte first and then high byte. The reads go through an external
// SPI monarch. A completed burst is published to ch_data in a single cycle,
// together with a one-cycle vld pulse.
//
// Parameters
//   NUM_CH     channels per burst (1..6); channel k at BASE_ADDR+2k (low)
//              and BASE_ADDR+2k+1 (high)
//   BASE_ADDR  sensor register address of channel 0 low byte
//   POR_BITS   post-reset wait is 2^POR_BITS clocks
//   GAP_BITS   wait between init writes is 2^GAP_BITS clocks
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   INT        sensor data-ready, asynchronous level
//   wrt        one-cycle start pulse to the SPI monarch (registered)
//   cmd        SPI command {R/W, addr[6:0], data[7:0]} (registered)
//   done       SPI transaction complete, one cycle
//   rd_data    SPI read data, byte in [7:0]
//   ch_data    channel k at [16k+15:16k], signed
//   vld        one-cycle pulse when ch_data is updated
//   ovr        one-cycle pulse when an INT edge arrives outside IDLE/PUBLISH
//   init_done  high once the init sequence is complete
//
// Build option: define INERT_OVR_EN to include the overrun detector.
// Without it, ovr is tied low.
// -----------------------------------------------------------------------------
module inert_burst_rdr #(
  parameter int unsigned NUM_CH    = 5,
  parameter logic [6:0]  BASE_ADDR = 7'h22,
  parameter int unsigned POR_BITS  = 16,
  parameter int unsigned GAP_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  INT,
  output logic                  wrt,
  output logic [15:0]           cmd,
  input  logic                  done,
  input  logic [15:0]           rd_data,
  output logic [16*NUM_CH-1:0]  ch_data,
  output logic                  vld,
  output logic                  ovr,
  output logic                  init_done
);

  // One timer serves both the power-on wait and the inter-write gap.
  localparam int unsigned TW = (POR_BITS > GAP_BITS) ? POR_BITS : GAP_BITS;

  typedef enum logic [2:0] {
    S_POR_WAIT,
    S_INIT_WR,
    S_INIT_DONE_WAIT,
    S_INIT_GAP,
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_PUBLISH
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_next;
  logic [2:0]    r_k;
  logic [2:0]    w_k_next;
  logic          r_byte_hi;
  logic          w_byte_hi_next;
  logic [7:0]    r_low;
  logic          r_int_s1;
  logic          r_int_s2;
  logic          r_wrt;
  logic [15:0]   r_cmd;
  logic          r_vld;
  logic          r_init_done;

  logic          w_timer_run;
  logic          w_cap_lo;
  logic          w_cap_hi;
  logic          w_last;
  logic          w_publish;
  logic [6:0]    w_rd_addr;
  logic [15:0]   w_init_word;
  logic          w_unused_rd_hi;

  // The sensor only drives the low byte. The upper byte is deliberately ignored.
  assign w_unused_rd_hi = ^rd_data[15:8];

  assign w_last    = (r_k == 3'(NUM_CH - 1));
  assign w_cap_lo  = (r_state == S_RD_WAIT) && done && !r_byte_hi;
  assign w_cap_hi  = (r_state == S_RD_WAIT) && done &&  r_byte_hi;
  assign w_publish = w_cap_hi && w_last;

  // The timer runs only while the FSM stays in a waiting state.
  // On every other cycle it reads zero, so each wait starts from a clean count.
  assign w_timer_run = ((r_state == S_POR_WAIT) || (r_state == S_INIT_GAP)) &&
                       (w_state_next == r_state);

  // The command is built from the next-state indices, so it is registered
  // on the same edge as wrt.
  assign w_rd_addr = BASE_ADDR + {3'b000, w_k_next, w_byte_hi_next};

  always_comb begin
    w_init_word = 16'h0D02;
    case (w_idx_next)
      2'd0: w_init_word = 16'h0D02;  // INT on data ready
      2'd1: w_init_word = 16'h1053;  // accel 208 Hz
      2'd2: w_init_word = 16'h1150;  // gyro 208 Hz
      2'd3: w_init_word = 16'h1460;  // rounding
      default: w_init_word = 16'h0D02;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_k_next       = r_k;
    w_byte_hi_next = r_byte_hi;
    case (r_state)
      S_POR_WAIT: begin
        if (&r_timer[POR_BITS-1:0]) w_state_next = S_INIT_WR;
      end
      S_INIT_WR: begin
        w_state_next = S_INIT_DONE_WAIT;
      end
      S_INIT_DONE_WAIT: begin
        if (done) w_state_next = (r_idx == 2'd3) ? S_IDLE : S_INIT_GAP;
      end
      S_INIT_GAP: begin
        if (&r_timer[GAP_BITS-1:0]) begin
          w_state_next = S_INIT_WR;
          w_idx_next   = r_idx + 2'd1;
        end
      end
      S_IDLE: begin
        if (r_int_s2) begin
          w_state_next   = S_RD_ISSUE;
          w_k_next       = 3'd0;
          w_byte_hi_next = 1'b0;
        end
      end
      S_RD_ISSUE: begin
        w_state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (done) begin
          if (!r_byte_hi) begin
            w_byte_hi_next = 1'b1;
            w_state_next   = S_RD_ISSUE;
          end else if (w_last) begin
            w_state_next = S_PUBLISH;
          end else begin
            w_k_next       = r_k + 3'd1;
            w_byte_hi_next = 1'b0;
            w_state_next   = S_RD_ISSUE;
          end
        end
      end
      S_PUBLISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_POR_WAIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_POR_WAIT;
      r_timer     <= '0;
      r_idx       <= 2'd0;
      r_k         <= 3'd0;
      r_byte_hi   <= 1'b0;
      r_low       <= 8'h00;
      r_int_s1    <= 1'b0;
      r_int_s2    <= 1'b0;
      r_wrt       <= 1'b0;
      r_cmd       <= 16'h0000;
      r_vld       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_run ? (r_timer + TW'(1)) : '0;
      r_idx     <= w_idx_next;
      r_k       <= w_k_next;
      r_byte_hi <= w_byte_hi_next;
      r_int_s1  <= INT;
      r_int_s2  <= r_int_s1;
      if (w_cap_lo) r_low <= rd_data[7:0];
      // wrt is high for exactly the cycle spent in an issue state.
      r_wrt <= (w_state_next == S_INIT_WR) || (w_state_next == S_RD_ISSUE);
      // cmd is loaded only when a new transaction is issued, so it holds
      // until the matching done arrives.
      if (w_state_next == S_INIT_WR) begin
        r_cmd <= w_init_word;
      end else if (w_state_next == S_RD_ISSUE) begin
        r_cmd <= {1'b1, w_rd_addr, 8'h00};
      end
      r_vld <= w_publish;
      if ((r_state == S_INIT_DONE_WAIT) && done && (r_idx == 2'd3)) r_init_done <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel shadow and output registers.
  // The output registers load on the edge that enters PUBLISH, so vld and the
  // new ch_data appear together. The last channel's high byte arrives on that
  // same edge, so it is taken straight from the bus instead of from its shadow.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [15:0] r_shadow;
      logic [15:0] r_ch;
      logic [15:0] w_pub;

      assign w_pub = (r_k == 3'(gi)) ? {rd_data[7:0], r_low} : r_shadow;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shadow <= 16'h0000;
          r_ch     <= 16'h0000;
        end else begin
          if (w_cap_hi && (r_k == 3'(gi))) r_shadow <= {rd_data[7:0], r_low};
          if (w_publish) r_ch <= w_pub;
        end
      end

      assign ch_data[16*gi +: 16] = r_ch;
    end
  endgenerate

`ifdef INERT_OVR_EN
  // An INT edge that arrives while a burst or the init sequence is running
  // means a sample was missed. The running burst continues; nothing is queued.
  logic r_int_s3;
  logic r_ovr;
  logic w_int_rise;

  assign w_int_rise = r_int_s2 && !r_int_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_s3 <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_int_s3 <= r_int_s2;
      r_ovr    <= w_int_rise && (r_state != S_IDLE) && (r_state != S_PUBLISH);
    end
  end

  assign ovr = r_ovr;
`else
  assign ovr = 1'b0;
`endif

  assign wrt       = r_wrt;
  assign cmd       = r_cmd;
  assign vld       = r_vld;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_inert_burst_rdr.sv
// -----------------------------------------------------------------------------
// tb_inert_burst_rdr
//
// Directed bench for inert_burst_rdr. It runs two instances side by side:
//   A: NUM_CH=5
//   B: NUM_CH=6
// Both use POR_BITS=4 and GAP_BITS=3. Each instance has its own SPI/sensor
// responder, which returns done 10 clocks after wrt.
//
// Sensor data: channel k reads as base + k*16'h1111, where base is set per
// burst. The upper byte of rd_data carries junk that the DUT must ignore.
// -----------------------------------------------------------------------------
module tb_inert_burst_rdr;

  logic        clk;
  logic        rst_n;
  logic        INT;

  logic        wrt_a, wrt_b;
  logic [15:0] cmd_a, cmd_b;
  logic        done_a, done_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [79:0] ch_data_a;
  logic [95:0] ch_data_b;
  logic        vld_a, vld_b, ovr_a, ovr_b, init_done_a, init_done_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] base;
  logic        stray_a;
  int          busy_a, cnt_a, busy_b, cnt_b;
  logic [15:0] log_a[$];
  logic [15:0] log_b[$];

  // Monitor state
  int vld_cnt_a = 0, vld_cnt_b = 0, ovr_cnt_a = 0, ovr_cnt_b = 0, wrt_cnt_a = 0;
  int chg_novld_a = 0, chg_novld_b = 0;
  int log_at_vld_a = 0, log_at_vld_b = 0;
  logic [79:0] cap_a = '0, prev_a = '0;
  logic [95:0] cap_b = '0, prev_b = '0;

  inert_burst_rdr #(.NUM_CH(5), .BASE_ADDR(7'h22), .POR_BITS(4), .GAP_BITS(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .INT(INT), .wrt(wrt_a), .cmd(cmd_a), .done(done_a),
    .rd_data(rd_data_a), .ch_data(ch_data_a), .vld(vld_a), .ovr(ovr_a),
    .init_done(init_done_a)
  );

  inert_burst_rdr #(.NUM_CH(6), .BASE_ADDR(7'h22), .POR_BITS(4), .GAP_BITS(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .INT(INT), .wrt(wrt_b), .cmd(cmd_b), .done(done_b),
    .rd_data(rd_data_b), .ch_data(ch_data_b), .vld(vld_b), .ovr(ovr_b),
    .init_done(init_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] byte_for(input logic [15:0] b, input logic [6:0] addr);
    logic [6:0]  off;
    logic [15:0] v;
    off = addr - 7'h22;
    v   = b + 16'h1111 * {10'd0, off[6:1]};
    return off[0] ? v[15:8] : v[7:0];
  endfunction

  // SPI/sensor responders: log each command, then answer 10 clocks later.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_a = 0; cnt_a = 0; done_a = 1'b0;
    end else begin
      done_a = 1'b0;
      if (stray_a) begin
        done_a  = 1'b1;
        stray_a = 1'b0;
      end
      if (busy_a != 0) begin
        cnt_a--;
        if (cnt_a == 0) begin
          busy_a    = 0;
          done_a    = 1'b1;
          rd_data_a = {8'hEE, byte_for(base, cmd_a[14:8])};
        end
      end else if (wrt_a) begin
        log_a.push_back(cmd_a);
        busy_a = 1;
        cnt_a  = 10;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_b = 0; cnt_b = 0; done_b = 1'b0;
    end else begin
      done_b = 1'b0;
      if (busy_b != 0) begin
        cnt_b--;
        if (cnt_b == 0) begin
          busy_b    = 0;
          done_b    = 1'b1;
          rd_data_b = {8'h5A, byte_for(base, cmd_b[14:8])};
        end
      end else if (wrt_b) begin
        log_b.push_back(cmd_b);
        busy_b = 1;
        cnt_b  = 10;
      end
    end
  end

  // Output monitor: count pulses and catch any ch_data change without vld.
  always @(negedge clk) begin
    if (vld_a) begin vld_cnt_a++; cap_a = ch_data_a; log_at_vld_a = log_a.size(); end
    if (vld_b) begin vld_cnt_b++; cap_b = ch_data_b; log_at_vld_b = log_b.size(); end
    if (ovr_a) ovr_cnt_a++;
    if (ovr_b) ovr_cnt_b++;
    if (wrt_a) wrt_cnt_a++;
    if (rst_n && !vld_a && (ch_data_a !== prev_a)) chg_novld_a++;
    if (rst_n && !vld_b && (ch_data_b !== prev_b)) chg_novld_b++;
    prev_a = ch_data_a;
    prev_b = ch_data_b;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges from now until wrt_a is seen; returns 0 if it never appears.
  task automatic find_wrt(input int limit, output int cyc);
    cyc = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (wrt_a) begin
        cyc = c;
        break;
      end
    end
  endtask

  logic [15:0] init_exp [4];
  int          lat;
  int          v0a, v0b, o0a, o0b, w0a, l0;
  int          exp_ovr;

  initial begin
    init_exp[0] = 16'h0D02; init_exp[1] = 16'h1053;
    init_exp[2] = 16'h1150; init_exp[3] = 16'h1460;
`ifdef INERT_OVR_EN
    exp_ovr = 1;
`else
    exp_ovr = 0;
`endif
    rst_n = 1'b0; INT = 1'b0; base = 16'h1234; stray_a = 1'b0;
    rd_data_a = 16'h0000; rd_data_b = 16'h0000;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_wrt", wrt_a, 1'b0);
    chk("rst_cmd", cmd_a, 16'h0000);
    chk("rst_ch_data", ch_data_a, 80'h0);
    chk("rst_vld", vld_a, 1'b0);
    chk("rst_ovr", ovr_a, 1'b0);
    chk("rst_init_done", init_done_a, 1'b0);
    $display("step reset: wrt=%0b cmd=%h init_done=%0b", wrt_a, cmd_a, init_done_a);

    // ---- POR wait and init sequence ----
    rst_n = 1'b1;
    find_wrt(40, lat);
    chk("first_init_wrt_clock", lat, 16);
    $display("step por: first wrt at clock %0d", lat);
    for (int c = 0; c < 600 && !(init_done_a && init_done_b); c++) @(negedge clk);
    chk("init_done_a", init_done_a, 1'b1);
    chk("init_done_b", init_done_b, 1'b1);
    chk("init_wr_count", log_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("init_cmd", log_a[i], init_exp[i]);
      $display("step init: write %0d cmd=%h", i, log_a[i]);
    end

    // ---- burst 1: INT high, 5 and 6 channels ----
    repeat (3) @(negedge clk);
    v0a = vld_cnt_a; v0b = vld_cnt_b; o0a = ovr_cnt_a; o0b = ovr_cnt_b;
    INT = 1'b1;
    find_wrt(20, lat);
    INT = 1'b0;
    chk("int_to_wrt_latency", lat, 3);
    repeat (200) @(negedge clk);
    chk("b1_vld_a_once", vld_cnt_a - v0a, 1);
    chk("b1_vld_b_once", vld_cnt_b - v0b, 1);
    chk("b1_ch_data_a", cap_a, 80'h5678_4567_3456_2345_1234);
    chk("b1_ch_data_b", cap_b, 96'h6789_5678_4567_3456_2345_1234);
    chk("b1_ch0_a", ch_data_a[15:0], 16'h1234);
    chk("b1_reads_at_vld_a", log_at_vld_a, 14);
    chk("b1_reads_at_vld_b", log_at_vld_b, 16);
    for (int j = 0; j < 10; j++) chk("b1_rd_cmd_a", log_a[4+j], 16'hA200 + 16'(j) * 16'h0100);
    for (int j = 0; j < 12; j++) chk("b1_rd_cmd_b", log_b[4+j], 16'hA200 + 16'(j) * 16'h0100);
    chk("b1_no_ovr_a", ovr_cnt_a - o0a, 0);
    chk("b1_no_ovr_b", ovr_cnt_b - o0b, 0);
    $display("step burst1: ch_data_a=%h ch_data_b=%h", cap_a, cap_b);

    // ---- burst 2: second INT edge mid-burst ----
    base = 16'hF0A5;
    v0a = vld_cnt_a; v0b = vld_cnt_b; o0a = ovr_cnt_a; o0b = ovr_cnt_b;
    INT = 1'b1;
    repeat (6) @(negedge clk);
    INT = 1'b0;
    repeat (30) @(negedge clk);
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
    repeat (200) @(negedge clk);
    chk("b2_ovr_a", ovr_cnt_a - o0a, exp_ovr);
    chk("b2_ovr_b", ovr_cnt_b - o0b, exp_ovr);
    chk("b2_vld_a_once", vld_cnt_a - v0a, 1);
    chk("b2_vld_b_once", vld_cnt_b - v0b, 1);
    chk("b2_ch_data_a", ch_data_a, 80'h34E9_23D8_12C7_01B6_F0A5);
    chk("b2_ch_data_b", ch_data_b, 96'h45FA_34E9_23D8_12C7_01B6_F0A5);
    $display("step burst2: ovr_a=%0d ch_data_a=%h", ovr_cnt_a - o0a, ch_data_a);

    // ---- stray done pulses in IDLE ----
    v0a = vld_cnt_a; w0a = wrt_cnt_a;
    for (int s = 0; s < 3; s++) begin
      stray_a = 1'b1;
      repeat (4) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("stray_no_vld", vld_cnt_a - v0a, 0);
    chk("stray_no_wrt", wrt_cnt_a - w0a, 0);
    chk("stray_ch_data", ch_data_a, 80'h34E9_23D8_12C7_01B6_F0A5);
    $display("step stray: vld=%0d wrt=%0d", vld_cnt_a - v0a, wrt_cnt_a - w0a);

    // ---- partial data never visible ----
    chk("no_change_without_vld_a", chg_novld_a, 0);
    chk("no_change_without_vld_b", chg_novld_b, 0);

    // ---- reset during the third read ----
    l0 = log_a.size();
    INT = 1'b1;
    for (int c = 0; c < 100 && log_a.size() < l0 + 3; c++) @(negedge clk);
    INT = 1'b0;
    chk("third_read_reached", log_a.size(), l0 + 3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wrt", wrt_a, 1'b0);
    chk("mid_rst_cmd", cmd_a, 16'h0000);
    chk("mid_rst_ch_data_a", ch_data_a, 80'h0);
    chk("mid_rst_ch_data_b", ch_data_b, 96'h0);
    chk("mid_rst_vld", vld_a, 1'b0);
    chk("mid_rst_ovr", ovr_a, 1'b0);
    chk("mid_rst_init_done", init_done_a, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    find_wrt(40, lat);
    chk("post_rst_first_wrt_clock", lat, 16);
    chk("post_rst_cmd", cmd_a, 16'h0D02);
    $display("step midreset: first wrt again at clock %0d", lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
